// File: rtl/ds_sched_pkg.sv
// Shared constants for the multi-rate down-sampling scheduler: FSM encodings,
// channel limits, config field widths and the drop-counter helper.
package ds_sched_pkg;

  localparam int STATE_W = 2;
  localparam logic [STATE_W-1:0] ST_IDLE  = 2'd0;
  localparam logic [STATE_W-1:0] ST_RUN   = 2'd1;
  localparam logic [STATE_W-1:0] ST_DRAIN = 2'd2;

  localparam int MAX_CH     = 8;
  localparam int CFG_CH_W   = 3;
  localparam int DROP_CNT_W = 8;

  function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
    return (&v) ? v : v + DROP_CNT_W'(1);
  endfunction

endpackage

// File: rtl/ds_sched_chan.sv
// One decimation channel: shadow/active ratio+phase, phase counter, 1-entry output
// holding register and sticky overrun. DS_SCHED_DROP_CNT_EN adds a saturating drop count.
module ds_sched_chan
  import ds_sched_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int RATIO_W = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_idle,
  input  logic               i_start,
  input  logic               i_accept,
  input  logic [DATA_W-1:0]  i_in_data,
  input  logic               i_cfg_wr,
  input  logic [RATIO_W-1:0] i_cfg_ratio,
  input  logic [RATIO_W-1:0] i_cfg_phase,
  input  logic               i_out_ready,
  input  logic               i_ovr_clr,
  output logic               o_out_valid,
  output logic [DATA_W-1:0]  o_out_data,
  output logic               o_overrun
`ifdef DS_SCHED_DROP_CNT_EN
  ,
  output logic [DROP_CNT_W-1:0] o_drop_cnt
`endif
);

  logic [RATIO_W-1:0] shadow_ratio;
  logic [RATIO_W-1:0] shadow_phase;
  logic [RATIO_W-1:0] act_ratio;
  logic [RATIO_W-1:0] act_phase;
  logic [RATIO_W-1:0] cnt;
  logic [RATIO_W-1:0] next_ratio;
  logic [RATIO_W-1:0] next_phase;
  logic               enabled;
  logic               step;
  logic               hit;
  logic               wrap;
  logic               load;
  logic               drop;

  // A write landing on the wrap cycle must be the value picked up by that wrap.
  assign next_ratio = i_cfg_wr ? i_cfg_ratio : shadow_ratio;
  assign next_phase = i_cfg_wr ? i_cfg_phase : shadow_phase;

  assign enabled = (act_ratio != '0);
  assign step    = i_accept && enabled;
  assign hit     = step && (cnt == act_phase);
  assign wrap    = step && (cnt == act_ratio - RATIO_W'(1));
  assign load    = !enabled || i_idle || wrap;
  assign drop    = hit && o_out_valid && !i_out_ready;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      shadow_ratio <= '0;
      shadow_phase <= '0;
      act_ratio    <= '0;
      act_phase    <= '0;
    end else begin
      shadow_ratio <= next_ratio;
      shadow_phase <= next_phase;
      if (load) begin
        act_ratio <= next_ratio;
        act_phase <= next_phase;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt <= '0;
    end else if (i_start || load) begin
      cnt <= '0;
    end else if (step) begin
      cnt <= cnt + RATIO_W'(1);
    end
  end

  // Holding register: a hit is only taken when the slot is free or being emptied.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_out_valid <= 1'b0;
      o_out_data  <= '0;
    end else if (hit && (!o_out_valid || i_out_ready)) begin
      o_out_valid <= 1'b1;
      o_out_data  <= i_in_data;
    end else if (o_out_valid && i_out_ready) begin
      o_out_valid <= 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_overrun <= 1'b0;
    end else if (drop) begin
      o_overrun <= 1'b1;
    end else if (i_ovr_clr) begin
      o_overrun <= 1'b0;
    end
  end

`ifdef DS_SCHED_DROP_CNT_EN
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_drop_cnt <= '0;
    end else if (i_ovr_clr) begin
      o_drop_cnt <= drop ? DROP_CNT_W'(1) : '0;
    end else if (drop) begin
      o_drop_cnt <= sat_inc(o_drop_cnt);
    end
  end
`endif

endmodule

// File: rtl/ds_rate_sched.sv
// Multi-rate down-sampling scheduler top: run/stop FSM, config decode, per-channel
// decimators and output packing. DS_SCHED_DROP_CNT_EN adds o_drop_cnt.
module ds_rate_sched
  import ds_sched_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int NUM_CH  = 3,
  parameter int RATIO_W = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_en,
  input  logic                     i_cfg_wr,
  input  logic [CFG_CH_W-1:0]      i_cfg_ch,
  input  logic [RATIO_W-1:0]       i_cfg_ratio,
  input  logic [RATIO_W-1:0]       i_cfg_phase,
  input  logic                     i_in_valid,
  input  logic [DATA_W-1:0]        i_in_data,
  output logic                     o_in_ready,
  output logic [NUM_CH-1:0]        o_out_valid,
  output logic [NUM_CH*DATA_W-1:0] o_out_data,
  input  logic [NUM_CH-1:0]        i_out_ready,
  input  logic                     i_ovr_clr,
  output logic [NUM_CH-1:0]        o_overrun,
  output logic                     o_busy
`ifdef DS_SCHED_DROP_CNT_EN
  ,
  output logic [NUM_CH*DROP_CNT_W-1:0] o_drop_cnt
`endif
);

  logic [STATE_W-1:0] state;
  logic [STATE_W-1:0] state_nxt;
  logic               idle;
  logic               start;
  logic               accept;

  assign idle       = (state == ST_IDLE);
  assign start      = idle && i_en;
  assign o_in_ready = (state == ST_RUN);
  assign o_busy     = !idle;
  assign accept     = i_in_valid && o_in_ready;

  // DRAIN waits for every holding register to empty unless the run request returns.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (i_en) state_nxt = ST_RUN;
      ST_RUN:   if (!i_en) state_nxt = ST_DRAIN;
      ST_DRAIN: begin
        if (i_en) begin
          state_nxt = ST_RUN;
        end else if (o_out_valid == '0) begin
          state_nxt = ST_IDLE;
        end
      end
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic cfg_wr_ch;

    assign cfg_wr_ch = i_cfg_wr && (i_cfg_ch == CFG_CH_W'(g));

    ds_sched_chan #(
      .DATA_W  (DATA_W),
      .RATIO_W (RATIO_W)
    ) u_chan (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_idle      (idle),
      .i_start     (start),
      .i_accept    (accept),
      .i_in_data   (i_in_data),
      .i_cfg_wr    (cfg_wr_ch),
      .i_cfg_ratio (i_cfg_ratio),
      .i_cfg_phase (i_cfg_phase),
      .i_out_ready (i_out_ready[g]),
      .i_ovr_clr   (i_ovr_clr),
      .o_out_valid (o_out_valid[g]),
      .o_out_data  (o_out_data[g*DATA_W +: DATA_W]),
      .o_overrun   (o_overrun[g])
`ifdef DS_SCHED_DROP_CNT_EN
      ,
      .o_drop_cnt  (o_drop_cnt[g*DROP_CNT_W +: DROP_CNT_W])
`endif
    );
  end

endmodule

// File: tb/tb_ds_rate_sched.sv
// Scoreboard bench for ds_rate_sched; build with DS_SCHED_DROP_CNT_EN to also check o_drop_cnt.
module tb_ds_rate_sched;

  localparam int DATA_W  = 16;
  localparam int NUM_CH  = 3;
  localparam int RATIO_W = 8;

  logic                     i_clk = 1'b0;
  logic                     i_rst = 1'b1;
  logic                     i_en = 1'b0;
  logic                     i_cfg_wr = 1'b0;
  logic [2:0]               i_cfg_ch = '0;
  logic [RATIO_W-1:0]       i_cfg_ratio = '0;
  logic [RATIO_W-1:0]       i_cfg_phase = '0;
  logic                     i_in_valid = 1'b0;
  logic [DATA_W-1:0]        i_in_data = '0;
  logic                     o_in_ready;
  logic [NUM_CH-1:0]        o_out_valid;
  logic [NUM_CH*DATA_W-1:0] o_out_data;
  logic [NUM_CH-1:0]        i_out_ready = '0;
  logic                     i_ovr_clr = 1'b0;
  logic [NUM_CH-1:0]        o_overrun;
  logic                     o_busy;
`ifdef DS_SCHED_DROP_CNT_EN
  logic [NUM_CH*8-1:0]      o_drop_cnt;
`endif

  typedef struct {
    logic [DATA_W-1:0] data;
    int                due;
  } exp_t;

  exp_t              sb_q[NUM_CH][$];
  int                vectors = 0;
  int                miscompares = 0;
  int                cyc = 0;
  logic [NUM_CH-1:0] seen_valid = '0;

  ds_rate_sched #(
    .DATA_W  (DATA_W),
    .NUM_CH  (NUM_CH),
    .RATIO_W (RATIO_W)
  ) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_en        (i_en),
    .i_cfg_wr    (i_cfg_wr),
    .i_cfg_ch    (i_cfg_ch),
    .i_cfg_ratio (i_cfg_ratio),
    .i_cfg_phase (i_cfg_phase),
    .i_in_valid  (i_in_valid),
    .i_in_data   (i_in_data),
    .o_in_ready  (o_in_ready),
    .o_out_valid (o_out_valid),
    .o_out_data  (o_out_data),
    .i_out_ready (i_out_ready),
    .i_ovr_clr   (i_ovr_clr),
    .o_overrun   (o_overrun),
`ifdef DS_SCHED_DROP_CNT_EN
    .o_drop_cnt  (o_drop_cnt),
`endif
    .o_busy      (o_busy)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Pops one expected sample per completed output handshake on each channel.
  always @(negedge i_clk) begin
    if (!i_rst) begin
      seen_valid <= seen_valid | o_out_valid;
      for (int ch = 0; ch < NUM_CH; ch++) begin
        if (o_out_valid[ch] && i_out_ready[ch]) begin
          if (sb_q[ch].size() == 0) begin
            checkOutput($sformatf("ch%0d_unexpected_valid", ch), 64'(o_out_valid[ch]), 64'd0);
          end else begin
            exp_t e;
            e = sb_q[ch].pop_front();
            checkOutput($sformatf("ch%0d_data", ch), 64'(o_out_data[ch*DATA_W +: DATA_W]), 64'(e.data));
            if (e.due >= 0) checkOutput($sformatf("ch%0d_latency", ch), 64'(cyc), 64'(e.due));
          end
        end
      end
    end
  end

  function automatic void expect_sample(input int ch, input logic [DATA_W-1:0] d, input int due);
    exp_t e;
    e.data = d;
    e.due  = due;
    sb_q[ch].push_back(e);
  endfunction

  task automatic applyStimulus(input logic [DATA_W-1:0] d);
    i_in_valid = 1'b1;
    i_in_data  = d;
    @(posedge i_clk);
    #1;
    i_in_valid = 1'b0;
  endtask

  task automatic cfg_write(input int ch, input int ratio, input int phase);
    i_cfg_wr    = 1'b1;
    i_cfg_ch    = 3'(ch);
    i_cfg_ratio = RATIO_W'(ratio);
    i_cfg_phase = RATIO_W'(phase);
    @(posedge i_clk);
    #1;
    i_cfg_wr = 1'b0;
  endtask

  task automatic start_run();
    i_en = 1'b1;
    @(posedge i_clk);
    #1;
    checkOutput("run_in_ready", 64'(o_in_ready), 64'd1);
  endtask

  task automatic stop_and_wait_idle(input string tag);
    int n;
    i_en = 1'b0;
    i_in_valid = 1'b0;
    n = 0;
    while (o_busy && n < 50) begin
      @(negedge i_clk);
      n++;
    end
    checkOutput({tag, "_idle"}, 64'(o_busy), 64'd0);
    checkOutput({tag, "_sb_empty"}, 64'(sb_q[0].size() + sb_q[1].size() + sb_q[2].size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset state
    #3;
    checkOutput("rst_busy", 64'(o_busy), 64'd0);
    checkOutput("rst_in_ready", 64'(o_in_ready), 64'd0);
    checkOutput("rst_out_valid", 64'(o_out_valid), 64'd0);
    checkOutput("rst_out_data", 64'(o_out_data), 64'd0);
    checkOutput("rst_overrun", 64'(o_overrun), 64'd0);
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b0;
    @(posedge i_clk);
    #1;

    // Basic decimation: ch0 R2P0, ch1 R4P1, ch2 R8P7
    $display("[TB] basic decimation");
    cfg_write(0, 2, 0);
    cfg_write(1, 4, 1);
    cfg_write(2, 8, 7);
    i_out_ready = 3'b111;
    start_run();
    for (int k = 0; k < 16; k++) begin
      if (k % 2 == 0) expect_sample(0, DATA_W'(k), cyc + 1);
      if (k % 4 == 1) expect_sample(1, DATA_W'(k), cyc + 1);
      if (k % 8 == 7) expect_sample(2, DATA_W'(k), cyc + 1);
      applyStimulus(DATA_W'(k));
    end
    stop_and_wait_idle("basic");

    // Overrun on a stalled consumer
    $display("[TB] overrun");
    cfg_write(0, 2, 0);
    cfg_write(1, 0, 0);
    cfg_write(2, 0, 0);
    i_out_ready = 3'b110;
    start_run();
    for (int k = 0; k < 6; k++) begin
      if (k == 0) expect_sample(0, 16'h0300, -1);
      applyStimulus(DATA_W'(16'h0300 + k));
      checkOutput($sformatf("ovr_hold_valid_k%0d", k), 64'(o_out_valid[0]), 64'd1);
      checkOutput($sformatf("ovr_hold_data_k%0d", k), 64'(o_out_data[DATA_W-1:0]), 64'h0300);
      checkOutput($sformatf("ovr_flag_k%0d", k), 64'(o_overrun), (k >= 2) ? 64'd1 : 64'd0);
    end
`ifdef DS_SCHED_DROP_CNT_EN
    checkOutput("ovr_drop_cnt", 64'(o_drop_cnt[7:0]), 64'd2);
`endif
    i_ovr_clr = 1'b1;
    @(posedge i_clk);
    #1;
    i_ovr_clr = 1'b0;
    checkOutput("ovr_cleared", 64'(o_overrun), 64'd0);
`ifdef DS_SCHED_DROP_CNT_EN
    checkOutput("ovr_drop_cnt_cleared", 64'(o_drop_cnt), 64'd0);
`endif
    i_out_ready = 3'b111;
    stop_and_wait_idle("overrun");

    // Reconfigure ch1 R4P1 -> R3P2 while counter is 1; takes effect at the wrap
    $display("[TB] reconfig at wrap");
    cfg_write(0, 0, 0);
    cfg_write(1, 4, 1);
    cfg_write(2, 0, 0);
    start_run();
    for (int k = 0; k < 16; k++) begin
      if (k == 1 || (k >= 4 && (k - 4) % 3 == 2)) expect_sample(1, DATA_W'(16'h0400 + k), cyc + 1);
      if (k == 1) begin
        i_cfg_wr    = 1'b1;
        i_cfg_ch    = 3'd1;
        i_cfg_ratio = 8'd3;
        i_cfg_phase = 8'd2;
      end
      applyStimulus(DATA_W'(16'h0400 + k));
      i_cfg_wr = 1'b0;
    end
    stop_and_wait_idle("reconfig");

    // Drain sequencing with a held sample
    $display("[TB] drain");
    cfg_write(0, 2, 0);
    cfg_write(1, 0, 0);
    i_out_ready = 3'b110;
    start_run();
    expect_sample(0, 16'h00A0, -1);
    applyStimulus(16'h00A0);
    applyStimulus(16'h00A1);
    i_en = 1'b0;
    @(posedge i_clk);
    #1;
    checkOutput("drain_busy", 64'(o_busy), 64'd1);
    checkOutput("drain_in_ready", 64'(o_in_ready), 64'd0);
    checkOutput("drain_held_valid", 64'(o_out_valid[0]), 64'd1);
    @(posedge i_clk);
    #1;
    checkOutput("drain_still_busy", 64'(o_busy), 64'd1);
    i_out_ready = 3'b111;
    @(posedge i_clk);
    #1;
    checkOutput("drain_valid_fell", 64'(o_out_valid[0]), 64'd0);
    checkOutput("drain_busy_one_more", 64'(o_busy), 64'd1);
    @(posedge i_clk);
    #1;
    checkOutput("drain_idle", 64'(o_busy), 64'd0);
    checkOutput("drain_sb_empty", 64'(sb_q[0].size()), 64'd0);

    // Phase >= ratio and ratio 0 never hit; ratio 1 hits every input
    $display("[TB] boundary ratios");
    cfg_write(0, 4, 5);
    cfg_write(1, 0, 0);
    cfg_write(2, 1, 0);
    seen_valid = '0;
    start_run();
    for (int k = 0; k < 32; k++) begin
      expect_sample(2, DATA_W'(16'h0600 + k), cyc + 1);
      applyStimulus(DATA_W'(16'h0600 + k));
    end
    stop_and_wait_idle("boundary");
    checkOutput("boundary_ch01_never_valid", 64'(seen_valid[1:0]), 64'd0);

    // Asynchronous reset mid-operation
    $display("[TB] async reset");
    cfg_write(0, 1, 0);
    cfg_write(2, 0, 0);
    i_out_ready = 3'b110;
    start_run();
    expect_sample(0, 16'h0700, -1);
    applyStimulus(16'h0700);
    applyStimulus(16'h0701);
    checkOutput("prerst_overrun", 64'(o_overrun[0]), 64'd1);
    #2;
    i_rst = 1'b1;
    #1;
    checkOutput("midrst_busy", 64'(o_busy), 64'd0);
    checkOutput("midrst_in_ready", 64'(o_in_ready), 64'd0);
    checkOutput("midrst_out_valid", 64'(o_out_valid), 64'd0);
    checkOutput("midrst_out_data", 64'(o_out_data), 64'd0);
    checkOutput("midrst_overrun", 64'(o_overrun), 64'd0);
`ifdef DS_SCHED_DROP_CNT_EN
    checkOutput("midrst_drop_cnt", 64'(o_drop_cnt), 64'd0);
`endif
    for (int ch = 0; ch < NUM_CH; ch++) sb_q[ch].delete();
    i_en = 1'b0;
    @(negedge i_clk);
    i_rst = 1'b0;
    i_out_ready = 3'b111;
    seen_valid = '0;
    start_run();
    for (int k = 0; k < 8; k++) applyStimulus(DATA_W'(16'h0800 + k));
    stop_and_wait_idle("postrst");
    checkOutput("postrst_cfg_discarded", 64'(seen_valid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
